// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Package     : cpu_mem_pkg
// Description : Shared memory-path definitions: store size codes, store FSM
//               state encoding and request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        WR   = 3'd3,
        DN   = 3'd4
    } state_t;

    // Misaligned word/half accesses and the reserved size code are rejected.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            SZ_WORD: r = (off != 2'b00);
            SZ_HALF: r = off[0];
            SZ_BYTE: r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_merge.sv
// ============================================================================
// Module      : store_lane_merge
// Description : Little-endian lane merge of new store data into an old word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_lane_merge
    import cpu_mem_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = i_old;
        case (i_size)
            SZ_WORD: o_word = i_new;
            SZ_HALF: begin
                if (i_off[1]) o_word[31:16] = i_new[15:0];
                else          o_word[15:0]  = i_new[15:0];
            end
            SZ_BYTE: begin
                case (i_off)
                    2'd0:    o_word[7:0]   = i_new[7:0];
                    2'd1:    o_word[15:8]  = i_new[7:0];
                    2'd2:    o_word[23:16] = i_new[7:0];
                    default: o_word[31:24] = i_new[7:0];
                endcase
            end
            default: o_word = i_old;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/store_rmw_unit.sv
// ============================================================================
// Module      : store_rmw_unit
// Description : Word/half/byte store engine; sub-word stores use
//               read-modify-write against a word-addressed memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_rmw_unit
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] c_LAT_INIT = 2'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [31:0] r_old;
    logic [1:0]  r_cnt;
    logic        r_err;
    logic        w_illegal;
    logic [31:0] w_merged;

    assign w_illegal = is_illegal(size, addr[1:0]);

    store_lane_merge u_merge (
        .i_old  (r_old),
        .i_new  (r_wdata),
        .i_size (r_size),
        .i_off  (r_addr[1:0]),
        .o_word (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= SZ_WORD;
            r_old   <= 32'd0;
            r_cnt   <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= addr;
                        r_wdata <= wdata_in;
                        r_size  <= size;
                        r_err   <= w_illegal;
                    end
                end
                RD: r_cnt <= c_LAT_INIT;
                WT: begin
                    // Read data is valid in the cycle the countdown reaches zero.
                    if (r_cnt == 2'd0) r_old <= mem_rdata;
                    else               r_cnt <= r_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_illegal)            w_next = DN;
                    else if (size == SZ_WORD) w_next = WR;
                    else                      w_next = RD;
                end
            end
            RD:      w_next = WT;
            WT:      if (r_cnt == 2'd0) w_next = WR;
            WR:      w_next = DN;
            DN:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wr    = 1'b0;
        busy      = (r_state != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        if (r_state != IDLE) mem_addr = {r_addr[31:2], 2'b00};
        if (r_state == WR) begin
            mem_wr    = 1'b1;
            mem_wdata = w_merged;
        end
        if (r_state == DN) begin
            done = 1'b1;
            err  = r_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
// ============================================================================
// Module      : tb_store_rmw_unit
// Description : Scoreboard bench for store_rmw_unit at MEM_LAT=1 and MEM_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_rmw_unit;
    import cpu_mem_pkg::*;

    typedef struct {
        bit          is_wr;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic [1:0]  size   = 2'b00;
    logic [31:0] addr   = 32'd0;
    logic [31:0] wdata  = 32'd0;
    logic [31:0] mem_word = 32'h11223344;

    logic [31:0] rdata1, maddr1, mwdata1;
    logic        mwr1, busy1, done1, err1;
    logic [31:0] rdata3, maddr3, mwdata3;
    logic        mwr3, busy3, done3, err3;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   fin    = 1'b0;
    logic rst_q  = 1'b1;

    store_rmw_unit #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst), .start(start1), .size(size), .addr(addr),
        .wdata_in(wdata), .mem_rdata(rdata1), .mem_addr(maddr1), .mem_wdata(mwdata1),
        .mem_wr(mwr1), .busy(busy1), .done(done1), .err(err1)
    );

    store_rmw_unit #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst), .start(start3), .size(size), .addr(addr),
        .wdata_in(wdata), .mem_rdata(rdata3), .mem_addr(maddr3), .mem_wdata(mwdata3),
        .mem_wr(mwr3), .busy(busy3), .done(done3), .err(err3)
    );

    always #5 clk = ~clk;

    // Memory model: read data is valid only in the cycle MEM_LAT after RD.
    logic busy1_q = 1'b0, busy3_q = 1'b0;
    int   k1 = 0, k3 = 0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_q   <= rst;
        busy1_q <= busy1;
        busy3_q <= busy3;
        if (busy1 && !busy1_q && !mwr1 && !done1) k1 <= 1;
        else if (k1 > 0)                          k1 <= k1 - 1;
        if (busy3 && !busy3_q && !mwr3 && !done3) k3 <= 3;
        else if (k3 > 0)                          k3 <= k3 - 1;
    end
    assign rdata1 = (k1 == 1) ? mem_word : 32'hBAD0BAD0;
    assign rdata3 = (k3 == 1) ? mem_word : 32'hBAD0BAD0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic check_evt(input string tag, input exp_t e, input logic wr,
                             input logic er, input logic [31:0] a, input logic [31:0] d);
        chk({tag, " event kind"}, {31'd0, wr}, {31'd0, e.is_wr});
        chk({tag, " event cycle"}, cyc, e.cyc);
        if (e.is_wr) begin
            chk({tag, " write addr"}, a, e.addr);
            chk({tag, " write data"}, d, e.data);
        end else begin
            chk({tag, " done err"}, {31'd0, er}, {31'd0, e.err});
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a write or done.
    always @(negedge clk) begin
        exp_t e;
        if (fin) begin
            chk("dut1 queue drained", q1.size(), 32'd0);
            chk("dut3 queue drained", q3.size(), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end else if (cyc > 3000) begin
            chk("timeout", 32'd1, 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end else if (cyc > 0) begin
            if (rst_q) begin
                chk("dut1 reset flags", {28'd0, busy1, done1, mwr1, err1}, 32'd0);
                chk("dut1 reset mem_addr", maddr1, 32'd0);
                chk("dut1 reset mem_wdata", mwdata1, 32'd0);
                chk("dut3 reset flags", {28'd0, busy3, done3, mwr3, err3}, 32'd0);
            end else begin
                if (mwr1 || done1) begin
                    if (q1.size() == 0) chk("dut1 unexpected event", {30'd0, mwr1, done1}, 32'd0);
                    else begin
                        e = q1.pop_front();
                        check_evt("dut1", e, mwr1, err1, maddr1, mwdata1);
                    end
                end
                if (mwr3 || done3) begin
                    if (q3.size() == 0) chk("dut3 unexpected event", {30'd0, mwr3, done3}, 32'd0);
                    else begin
                        e = q3.pop_front();
                        check_evt("dut3", e, mwr3, err3, maddr3, mwdata3);
                    end
                end
            end
        end
    end

    task automatic push(input int d, input exp_t e);
        if (d == 1) q1.push_back(e);
        else        q3.push_back(e);
    endtask

    // kind: 0 rejected, 1 word, 2 read-modify-write, 3 no expectation
    task automatic req(input int d, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int kind, input logic [31:0] ed,
                       input int lat);
        exp_t w, n;
        int   t;
        @(posedge clk); #1;
        size = sz; addr = a; wdata = wd;
        if (d == 1) start1 = 1'b1; else start3 = 1'b1;
        t = cyc;
        w.is_wr = 1'b1; w.addr = {a[31:2], 2'b00}; w.data = ed; w.err = 1'b0;
        n.is_wr = 1'b0; n.addr = 32'd0; n.data = 32'd0; n.err = (kind == 0);
        case (kind)
            0: begin n.cyc = t + 1; push(d, n); end
            1: begin w.cyc = t + 1; n.cyc = t + 2; push(d, w); push(d, n); end
            2: begin w.cyc = t + 2 + lat; n.cyc = t + 3 + lat; push(d, w); push(d, n); end
            default: ;
        endcase
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
    endtask

    initial begin
        exp_t w, n;
        int   t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        req(1, SZ_WORD, 32'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
        repeat (4) @(posedge clk);
        req(1, SZ_BYTE, 32'h23, 32'h000000AB, 2, 32'hAB223344, 1);
        repeat (5) @(posedge clk);
        req(1, SZ_HALF, 32'h42, 32'hFFFF5566, 2, 32'h55663344, 1);
        repeat (5) @(posedge clk);
        req(1, SZ_BYTE, 32'h20, 32'hFFFFFFCD, 2, 32'h112233CD, 1);
        repeat (5) @(posedge clk);
        req(1, SZ_HALF, 32'h44, 32'h1234ABCD, 2, 32'h1122ABCD, 1);
        repeat (5) @(posedge clk);
        mem_word = 32'hCAFEF00D;
        req(1, SZ_BYTE, 32'h61, 32'h00000012, 2, 32'hCAFE120D, 1);
        repeat (5) @(posedge clk);
        mem_word = 32'h11223344;

        req(1, SZ_ILL,  32'h00, 32'h12345678, 0, 32'd0, 1);
        repeat (3) @(posedge clk);
        req(1, SZ_HALF, 32'h41, 32'h12345678, 0, 32'd0, 1);
        repeat (3) @(posedge clk);
        req(1, SZ_WORD, 32'h02, 32'h12345678, 0, 32'd0, 1);
        repeat (3) @(posedge clk);

        // start held from the request through DN and one more IDLE cycle
        @(posedge clk); #1;
        size = SZ_WORD; addr = 32'h30; wdata = 32'h0BADF00D; start1 = 1'b1;
        t = cyc;
        w.is_wr = 1'b1; w.addr = 32'h30; w.data = 32'h0BADF00D; w.err = 1'b0;
        n.is_wr = 1'b0; n.addr = 32'd0;  n.data = 32'd0;        n.err = 1'b0;
        w.cyc = t + 1; n.cyc = t + 2; push(1, w); push(1, n);
        w.cyc = t + 4; n.cyc = t + 5; push(1, w); push(1, n);
        repeat (4) @(posedge clk);
        #1 start1 = 1'b0;
        repeat (5) @(posedge clk);

        // reset while the byte store sits in WT: its write must never appear
        req(1, SZ_BYTE, 32'h23, 32'h000000AB, 3, 32'd0, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        req(1, SZ_WORD, 32'h84, 32'h600DCAFE, 1, 32'h600DCAFE, 1);
        repeat (4) @(posedge clk);

        // MEM_LAT=3 byte store with ignored start pulses while busy
        req(3, SZ_BYTE, 32'h22, 32'h0000005A, 2, 32'h115A3344, 3);
        @(posedge clk); #1;
        size = SZ_WORD; addr = 32'h50; wdata = 32'hFFFFFFFF; start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        repeat (6) @(posedge clk);
        req(3, SZ_HALF, 32'h46, 32'h0000BEEF, 2, 32'hBEEF3344, 3);
        repeat (8) @(posedge clk);

        for (int i = 0; i < 50 && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
        fin = 1'b1;
    end

endmodule

`default_nettype wire
